// File: rtl/stb_pkg.sv
// -----------------------------------------------------------------------------
// stb_pkg
// Shared definitions for the store-buffer controllers (dcache side and LSU
// side). Holds the dcache-side FSM state encoding.
// -----------------------------------------------------------------------------
package stb_pkg;

  // IDLE   : nothing presented; lets stb_empty settle between stores
  // WRITE  : head entry presented to dcache, waiting for ack
  // RETIRE : dcache accepted; pop the head entry when the LSU is not writing
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RETIRE = 2'd2
  } stb_cache_state_e;

endpackage

// File: rtl/stb_cache_controller_if.sv
// -----------------------------------------------------------------------------
// stb_cache_controller_if
// Bundles the store-buffer / dcache / LSU handshake signals of the dcache-side
// store-buffer controller.
//   master : controller view (drives dcache request, buffer pop, status)
//   slave  : environment view (store buffer, dcache and LSU)
// Signals:
//   stb_empty          buffer holds no valid entry
//   stb_wr_en          LSU writes the buffer this cycle (buffer ignores pops)
//   dcache2stb_ack     dcache accepted the presented store
//   lsu2stb_fence      LSU requests a full drain (level)
//   rd_sel             buffer read mux toward dcache
//   stb2dcache_w_en    store request valid to dcache
//   stb_rd_en          retire the head entry
//   stb2lsu_fence_done drain complete
//   stb_timeout_err    sticky dcache-ack timeout flag
//   stb_retired_cnt    count of retired stores (wraps)
// -----------------------------------------------------------------------------
interface stb_cache_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stb_empty;
  logic             stb_wr_en;
  logic             dcache2stb_ack;
  logic             lsu2stb_fence;
  logic             rd_sel;
  logic             stb2dcache_w_en;
  logic             stb_rd_en;
  logic             stb2lsu_fence_done;
  logic             stb_timeout_err;
  logic [CNT_W-1:0] stb_retired_cnt;

  modport master (
    input  stb_empty, stb_wr_en, dcache2stb_ack, lsu2stb_fence,
    output rd_sel, stb2dcache_w_en, stb_rd_en, stb2lsu_fence_done,
           stb_timeout_err, stb_retired_cnt
  );

  modport slave (
    output stb_empty, stb_wr_en, dcache2stb_ack, lsu2stb_fence,
    input  rd_sel, stb2dcache_w_en, stb_rd_en, stb2lsu_fence_done,
           stb_timeout_err, stb_retired_cnt
  );
endinterface

// File: rtl/stb_ack_watchdog.sv
// -----------------------------------------------------------------------------
// stb_ack_watchdog
// Counts WRITE cycles without a dcache ack and raises a sticky error once
// TIMEOUT_CYCLES such cycles have elapsed since the last clear.
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   i_clear    restart the count (entry into WRITE); error is not cleared
//   i_count_en one more WRITE cycle without ack
//   o_err      sticky timeout error, cleared only by reset
// -----------------------------------------------------------------------------
module stb_ack_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_err
);
  localparam int unsigned       CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Saturating no-ack counter; the error sets on the edge the count reaches LIMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == (LIMIT - CW'(1))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
endmodule

// File: rtl/stb_cache_controller.sv
// -----------------------------------------------------------------------------
// stb_cache_controller
// Drains the store buffer into the dcache one entry at a time:
// IDLE -> WRITE (hold request until ack) -> RETIRE (pop head) -> IDLE.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous reset, active-high (asserted = 1)
//   bus    stb_cache_controller_if.master handshake bundle
// Parameters:
//   TIMEOUT_CYCLES  no-ack WRITE cycles before stb_timeout_err sets
//   CNT_W           width of the retired-store counter
// -----------------------------------------------------------------------------
module stb_cache_controller
  import stb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  stb_cache_controller_if.master       bus
);
  stb_cache_state_e  r_state;
  stb_cache_state_e  w_state_nxt;
  logic [CNT_W-1:0]  r_retired_cnt;
  logic              w_rd_sel;
  logic              w_w_en;
  logic              w_rd_en;
  logic              w_wd_clear;
  logic              w_wd_count;
  logic              w_timeout_err;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_rd_sel    = 1'b0;
    w_w_en      = 1'b0;
    w_rd_en     = 1'b0;
    w_wd_clear  = 1'b0;
    w_wd_count  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.stb_empty) begin
          w_state_nxt = WRITE;
          w_wd_clear  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WRITE: begin
        w_rd_sel = 1'b1;
        w_w_en   = 1'b1;
        if (bus.dcache2stb_ack) begin
          w_state_nxt = RETIRE;
        end else begin
          w_state_nxt = WRITE;
          w_wd_count  = 1'b1;
        end
      end
      RETIRE: begin
        // The buffer ignores pops while the LSU writes; a pop during reset
        // would retire an entry the buffer is discarding anyway.
        w_rd_en = !bus.stb_wr_en && !rst_n;
        if (w_rd_en) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RETIRE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Retired-store counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_retired_cnt <= '0;
    end else if (w_rd_en) begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end else begin
      r_retired_cnt <= r_retired_cnt;
    end
  end

  stb_ack_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst_n),
    .i_clear    (w_wd_clear),
    .i_count_en (w_wd_count),
    .o_err      (w_timeout_err)
  );

  assign bus.rd_sel             = w_rd_sel;
  assign bus.stb2dcache_w_en    = w_w_en;
  assign bus.stb_rd_en          = w_rd_en;
  assign bus.stb_timeout_err    = w_timeout_err;
  assign bus.stb_retired_cnt    = r_retired_cnt;
  assign bus.stb2lsu_fence_done = bus.lsu2stb_fence && (r_state == IDLE) && bus.stb_empty;
endmodule

// File: doc/stb_cache_controller.md
STB_CACHE_CONTROLLER -- requirements
Module: stb_cache_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles in WRITE without dcache ack before the timeout error sets.
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-store counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous reset, active-high (asserted = 1).
REQ-006 SHALL have port stb_empty  in  1  store buffer holds no valid entry.
REQ-007 SHALL have port stb_wr_en  in  1  LSU write into the store buffer this cycle; the buffer ignores stb_rd_en while this is high.
REQ-008 SHALL have port dcache2stb_ack  in  1  dcache accepted the presented store.
REQ-009 SHALL have port lsu2stb_fence  in  1  level; LSU requests a full drain.
REQ-010 SHALL have port rd_sel  out  1  enables the store buffer read mux toward dcache.
REQ-011 SHALL have port stb2dcache_w_en  out  1  store request valid to dcache.
REQ-012 SHALL have port stb_rd_en  out  1  retires the head entry of the store buffer.
REQ-013 SHALL have port stb2lsu_fence_done  out  1  drain complete.
REQ-014 SHALL have port stb_timeout_err  out  1  sticky dcache-ack timeout flag.
REQ-015 SHALL have port stb_retired_cnt  out  CNT_W  count of retired stores.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, RETIRE; reset state IDLE.
REQ-017 IDLE: rd_sel=0, stb2dcache_w_en=0, stb_rd_en=0; go to WRITE next cycle if stb_empty=0, else stay.
REQ-018 WRITE: rd_sel=1, stb2dcache_w_en=1; hold until dcache2stb_ack=1, then go to RETIRE; the request stays asserted and stable until ack.
REQ-019 RETIRE: rd_sel=0, stb2dcache_w_en=0, stb_rd_en=!stb_wr_en; go to IDLE only in a cycle where stb_rd_en=1, else stay in RETIRE.
REQ-020 SHALL never assert stb_rd_en outside RETIRE, and SHALL assert it at most one cycle per retired entry.
REQ-021 Minimum cost per store SHALL be 3 cycles (IDLE, WRITE with ack, RETIRE); back-to-back stores SHALL pass through IDLE so that stb_empty settles.
REQ-022 Ack in IDLE or RETIRE SHALL be ignored.
REQ-023 Timeout counter SHALL clear on entry to WRITE and increment each WRITE cycle without ack.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES, stb_timeout_err SHALL set next cycle and hold until reset; the FSM keeps waiting in WRITE.
REQ-025 stb_retired_cnt SHALL increment by 1 on each cycle where stb_rd_en=1, and SHALL wrap modulo 2^CNT_W.
REQ-026 stb2lsu_fence_done SHALL be combinational: lsu2stb_fence && state==IDLE && stb_empty.
REQ-027 Fence SHALL NOT alter FSM sequencing; new LSU writes during a fence delay fence_done until they drain.

Reset
REQ-028 Reset asserted on a clock edge SHALL force state IDLE, timeout counter 0, stb_timeout_err 0, stb_retired_cnt 0; all FSM outputs SHALL be 0 in the following cycle.
REQ-029 Reset mid-WRITE or mid-RETIRE SHALL abandon the transaction without issuing stb_rd_en; the store buffer is reset in the same cycle.

Structure
REQ-030 The state enum stb_cache_state_e (IDLE, WRITE, RETIRE) SHALL live in shared package stb_pkg, which is also used by the LSU-side controller.
REQ-031 The timeout watchdog SHALL be the single sub-module stb_ack_watchdog (inputs: clear, count enable; output: sticky error); all other logic stays flat.

Verification
REQ-032 Single store: stb_empty falls at cycle 0, ack at cycle 3 -> WRITE in cycles 1-3, stb_rd_en=1 in cycle 4, IDLE in cycle 5, retired_cnt=1.
REQ-033 Write collision: stb_wr_en held high for cycles 4-6 while in RETIRE -> stb_rd_en=0 in cycles 4-6, =1 in cycle 7, exactly one retire.
REQ-034 Timeout: TIMEOUT_CYCLES=4 and no ack -> stb_timeout_err=1 after 4 WRITE cycles; a later ack still completes the retire, and the error stays 1.
REQ-035 Fence: 3 entries queued and fence held -> fence_done=0 until the third retire, then 1 in the first IDLE cycle with stb_empty=1.
REQ-036 Reset mid-WRITE: reset in cycle 2 of WRITE with ack also high -> no stb_rd_en, all outputs 0, retired_cnt=0 next cycle.
REQ-037 Counter wrap: CNT_W=2 with 5 stores -> stb_retired_cnt reads 1.
